// File: rtl/dct_1d_seq.sv
// dct_1d_seq: time-multiplexed 1-D DCT, y = C*x, NUM_LANES serial MAC lanes, round-half-up and saturating outputs.
// Optional feature macro DCT_INVERSE_EN adds the inverse port (transposed coefficient matrix).
module dct_1d_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 14,
  parameter int N_POINTS   = 8,
  parameter int NUM_LANES  = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [DATA_WIDTH*N_POINTS-1:0]          data_in,
  input  logic [DATA_WIDTH*N_POINTS*N_POINTS-1:0] coeff_vector,
`ifdef DCT_INVERSE_EN
  input  logic                                    inverse,
`endif
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [DATA_WIDTH*N_POINTS-1:0]          dct_out,
  output logic                                    busy
);

  localparam int K_W    = $clog2(N_POINTS);
  localparam int GROUPS = N_POINTS / NUM_LANES;
  localparam int G_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int ACC_W  = 2*DATA_WIDTH + $clog2(N_POINTS);
  localparam logic [K_W-1:0] K_LAST = K_W'(N_POINTS - 1);
  localparam logic [G_W-1:0] G_LAST = G_W'(GROUPS - 1);
  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_e;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is high only in IDLE; out_valid is high only in DONE, with dct_out held until out_ready.
  state_e state_q, state_d;
  logic [K_W-1:0] k_q, k_d;
  logic [G_W-1:0] g_q, g_d;
  logic signed [DATA_WIDTH-1:0] x_q [N_POINTS];
  logic signed [DATA_WIDTH-1:0] x_d [N_POINTS];
  logic signed [DATA_WIDTH-1:0] y_q [N_POINTS];
  logic signed [DATA_WIDTH-1:0] y_d [N_POINTS];
  logic signed [ACC_W-1:0] acc_q [NUM_LANES];
  logic signed [ACC_W-1:0] acc_d [NUM_LANES];
`ifdef DCT_INVERSE_EN
  logic inv_q, inv_d;
`endif

  logic signed [DATA_WIDTH-1:0]   coef_m    [N_POINTS][N_POINTS];
  logic [K_W-1:0]                 lane_row  [NUM_LANES];
  logic signed [DATA_WIDTH-1:0]   lane_coef [NUM_LANES];
  logic signed [2*DATA_WIDTH-1:0] lane_prod [NUM_LANES];
  logic signed [ACC_W-1:0]        lane_sum  [NUM_LANES];
  logic signed [ACC_W-1:0]        lane_rnd  [NUM_LANES];
  logic signed [DATA_WIDTH-1:0]   lane_y    [NUM_LANES];

  always_comb begin
    for (int r = 0; r < N_POINTS; r++) begin
      for (int c = 0; c < N_POINTS; c++) begin
        coef_m[r][c] = coeff_vector[(r*N_POINTS+c)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Lane j works on row g*NUM_LANES+j; its result is only stored on the last column.
  always_comb begin
    for (int j = 0; j < NUM_LANES; j++) begin
      lane_row[j] = K_W'(int'(g_q) * NUM_LANES + j);
`ifdef DCT_INVERSE_EN
      lane_coef[j] = inv_q ? coef_m[k_q][lane_row[j]] : coef_m[lane_row[j]][k_q];
`else
      lane_coef[j] = coef_m[lane_row[j]][k_q];
`endif
      lane_prod[j] = lane_coef[j] * x_q[k_q];
      lane_sum[j]  = acc_q[j] + {{(ACC_W-2*DATA_WIDTH){lane_prod[j][2*DATA_WIDTH-1]}}, lane_prod[j]};
      lane_rnd[j]  = (lane_sum[j] + RND) >>> FRAC_BITS;
      if (lane_rnd[j] > SAT_MAX) begin
        lane_y[j] = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else if (lane_rnd[j] < SAT_MIN) begin
        lane_y[j] = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
        lane_y[j] = lane_rnd[j][DATA_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    g_d     = g_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
`ifdef DCT_INVERSE_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int k = 0; k < N_POINTS; k++) x_d[k] = data_in[k*DATA_WIDTH +: DATA_WIDTH];
          for (int j = 0; j < NUM_LANES; j++) acc_d[j] = '0;
`ifdef DCT_INVERSE_EN
          inv_d = inverse;
`endif
          k_d     = '0;
          g_d     = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        for (int j = 0; j < NUM_LANES; j++) begin
          if (k_q == K_LAST) begin
            y_d[lane_row[j]] = lane_y[j];
            acc_d[j]         = '0;
          end else begin
            acc_d[j] = lane_sum[j];
          end
        end
        k_d = k_q + 1'b1;
        if (k_q == K_LAST) begin
          g_d = g_q + 1'b1;
          if (g_q == G_LAST) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      g_q     <= '0;
      x_q     <= '{default: '0};
      y_q     <= '{default: '0};
      acc_q   <= '{default: '0};
`ifdef DCT_INVERSE_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      g_q     <= g_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
`ifdef DCT_INVERSE_EN
      inv_q   <= inv_d;
`endif
    end
  end

  always_comb begin
    dct_out = '0;
    for (int i = 0; i < N_POINTS; i++) dct_out[i*DATA_WIDTH +: DATA_WIDTH] = y_q[i];
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

endmodule
